// File: rtl/mac_tile_controller_if.sv
// mac_tile_controller_if
//   Groups the request, handshake and datapath-control signals between the
//   MAC tile controller (slave side) and whatever sequences it (master side).
//   Ports carried:
//     load_A, load_B, start, acc_mode, k_len, abort, out_ready  master -> slave
//     ld_a_en, ld_b_en, clear_acc, compute_en, k_index, busy,
//     done, out_valid, err_klen                                 slave -> master
//   K_MAX must match the controller's K_MAX so that k_len/k_index widths agree.
interface mac_tile_controller_if #(
  parameter int K_MAX = 16
);
  localparam int KW = $clog2(K_MAX + 1);

  logic          load_A;
  logic          load_B;
  logic          start;
  logic          acc_mode;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          out_ready;

  logic          ld_a_en;
  logic          ld_b_en;
  logic          clear_acc;
  logic          compute_en;
  logic [KW-1:0] k_index;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          err_klen;

  modport master (
    output load_A, load_B, start, acc_mode, k_len, abort, out_ready,
    input  ld_a_en, ld_b_en, clear_acc, compute_en, k_index,
           busy, done, out_valid, err_klen
  );

  modport slave (
    input  load_A, load_B, start, acc_mode, k_len, abort, out_ready,
    output ld_a_en, ld_b_en, clear_acc, compute_en, k_index,
           busy, done, out_valid, err_klen
  );
endinterface

// File: rtl/mac_tile_controller.sv
// mac_tile_controller
//   Sequencing FSM for the NxN 8-bit MAC array: operand-buffer loads,
//   accumulator clear, compute over a runtime reduction length, pipeline /
//   systolic drain, abort, and a valid/ready result handshake.
//   Ports:
//     clock    in  system clock
//     reset_n  in  asynchronous active-low reset
//     bus      mac_tile_controller_if.slave (requests in, controls/status out)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; loads pass through, legal start launches a tile
//   LOAD    | operand buffer load in progress, ld_*_en follow load_*
//   CLEAR   | one cycle of accumulator clear (skipped in accumulate mode)
//   SETUP   | one cycle of operand setup before compute
//   COMPUTE | MAC enabled, k_index steps 0..klen-1
//   DRAIN   | D cycles to flush datapath pipeline / systolic skew
//   DONE    | result held valid until out_ready
module mac_tile_controller #(
  parameter int N        = 4,
  parameter int K_MAX    = 16,
  parameter int PIPE_LAT = 2,
  parameter int SYSTOLIC = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mac_tile_controller_if.slave  bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int D  = PIPE_LAT + ((SYSTOLIC != 0) ? 2 * (N - 1) : 0);
  localparam int DW = (D > 0) ? $clog2(D + 1) : 1;
  // Drain counter is a down-counter; DONE follows the cycle it reads zero.
  localparam logic [DW-1:0] DRAIN_LOAD = (D > 0) ? DW'(D - 1) : '0;
  localparam logic [KW-1:0] K_MAX_W    = KW'(K_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    SETUP   = 3'd3,
    COMPUTE = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_index_q;
  logic [KW-1:0] klen_q;
  logic [DW-1:0] drain_cnt_q;

  logic klen_ok;
  logic last_k;
  logic launch;
  logic in_flight;
  logic abort_hit;
  logic compute_en_c;

  assign klen_ok   = (bus.k_len != '0) && (bus.k_len <= K_MAX_W);
  assign last_k    = (k_index_q == klen_q - KW'(1));
  assign in_flight = (state_q == CLEAR) || (state_q == SETUP) ||
                     (state_q == COMPUTE) || (state_q == DRAIN);
  assign abort_hit = in_flight && bus.abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    compute_en_c = 1'b0;
    bus.ld_a_en  = 1'b0;
    bus.ld_b_en  = 1'b0;
    bus.clear_acc = 1'b0;
    bus.err_klen = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ld_a_en = bus.load_A;
        bus.ld_b_en = bus.load_B;
        if (bus.load_A || bus.load_B) begin
          state_d = LOAD;
        end else if (bus.start) begin
          if (klen_ok) begin
            launch  = 1'b1;
            state_d = bus.acc_mode ? SETUP : CLEAR;
          end else begin
            bus.err_klen = 1'b1;
          end
        end
      end
      LOAD: begin
        bus.ld_a_en = bus.load_A;
        bus.ld_b_en = bus.load_B;
        if (!bus.load_A && !bus.load_B) state_d = IDLE;
      end
      CLEAR: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          bus.clear_acc = 1'b1;
          state_d       = SETUP;
        end
      end
      SETUP: state_d = bus.abort ? IDLE : COMPUTE;
      COMPUTE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          compute_en_c = 1'b1;
          if (last_k) state_d = (D > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (bus.abort)              state_d = IDLE;
        else if (drain_cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (bus.start) begin
            if (klen_ok) begin
              launch  = 1'b1;
              state_d = bus.acc_mode ? SETUP : CLEAR;
            end else begin
              bus.err_klen = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_index_q <= '0;
      klen_q    <= '0;
    end else if (launch) begin
      k_index_q <= '0;
      klen_q    <= bus.k_len;
    end else if (abort_hit) begin
      k_index_q <= '0;
    end else if (compute_en_c && !last_k) begin
      k_index_q <= k_index_q + KW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt_q <= '0;
    end else if (state_q == COMPUTE && state_d == DRAIN) begin
      drain_cnt_q <= DRAIN_LOAD;
    end else if (state_q == DRAIN && drain_cnt_q != '0) begin
      drain_cnt_q <= drain_cnt_q - DW'(1);
    end
  end

  assign bus.compute_en = compute_en_c;
  assign bus.k_index    = k_index_q;
  assign bus.busy       = in_flight;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_mac_tile_controller.sv
// tb_mac_tile_controller
//   Directed + randomized bench for mac_tile_controller. The reference model
//   is a timeline: for a tile launched in cycle 0, CLEAR is cycle 1 (unless
//   accumulating), compute occupies cycles off..off+klen-1 with off = 3 (2 when
//   accumulating), drain follows for D cycles, and the result is valid from
//   cycle off+klen+D.
module tb_mac_tile_controller;
  localparam int N        = 4;
  localparam int K_MAX    = 16;
  localparam int PIPE_LAT = 2;
  localparam int SYSTOLIC = 0;
  localparam int KW       = $clog2(K_MAX + 1);
  localparam int D        = PIPE_LAT + ((SYSTOLIC != 0) ? 2 * (N - 1) : 0);

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mac_tile_controller_if #(.K_MAX(K_MAX)) bus ();

  mac_tile_controller #(
    .N(N), .K_MAX(K_MAX), .PIPE_LAT(PIPE_LAT), .SYSTOLIC(SYSTOLIC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_A = 1'b0; bus.load_B = 1'b0; bus.start = 1'b0; bus.acc_mode = 1'b0;
    bus.k_len = '0; bus.abort = 1'b0; bus.out_ready = 1'b0;
  endtask

  // Launches a tile (or an illegal start) in cycle 0 and follows it until the
  // first DONE cycle, an abort, or the err_klen reject. in_done means the
  // launch cycle coincides with the handshake of a previous result.
  task automatic run_op(input int klen, input bit acc, input bit in_done,
                        input int abort_at, output bit finished);
    int  off, done_at, exp_k;
    bit  legal, ab;
    legal    = (klen >= 1) && (klen <= K_MAX);
    off      = acc ? 2 : 3;
    done_at  = off + klen + D;
    finished = 1'b0;

    next_cycle();
    idle_inputs();
    bus.start = 1'b1; bus.k_len = KW'(klen); bus.acc_mode = acc; bus.out_ready = in_done;
    settle();
    chk("err_klen_on_start", bus.err_klen, !legal);
    chk("out_valid_on_start", bus.out_valid, in_done);
    chk("busy_on_start", bus.busy, 0);

    if (!legal) begin
      next_cycle();
      idle_inputs();
      settle();
      chk("err_klen_one_cycle", bus.err_klen, 0);
      chk("busy_after_reject", bus.busy, 0);
      chk("out_valid_after_reject", bus.out_valid, 0);
      return;
    end

    for (int c = 1; c <= done_at; c++) begin
      next_cycle();
      idle_inputs();
      ab = (c == abort_at);
      bus.abort = ab;
      settle();
      if (c == done_at) begin
        chk("out_valid_at_done", bus.out_valid, 1);
        chk("done_at_done", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        chk("compute_at_done", bus.compute_en, 0);
        chk("k_index_at_done", bus.k_index, klen - 1);
        finished = 1'b1;
        return;
      end
      exp_k = (c < off) ? 0 : ((c - off < klen - 1) ? c - off : klen - 1);
      chk("busy_in_flight", bus.busy, 1);
      chk("out_valid_in_flight", bus.out_valid, 0);
      chk("clear_acc", bus.clear_acc, (!acc && c == 1 && !ab));
      chk("compute_en", bus.compute_en, (c >= off && c < off + klen && !ab));
      chk("k_index", bus.k_index, exp_k);
      if (ab) begin
        next_cycle();
        idle_inputs();
        settle();
        chk("busy_after_abort", bus.busy, 0);
        chk("k_index_after_abort", bus.k_index, 0);
        chk("out_valid_after_abort", bus.out_valid, 0);
        chk("compute_after_abort", bus.compute_en, 0);
        return;
      end
    end
  endtask

  // Holds DONE with out_ready low while loads and starts are thrown at it.
  task automatic hold_done(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      next_cycle();
      idle_inputs();
      bus.load_A = 1'($urandom_range(0, 1));
      bus.load_B = 1'($urandom_range(0, 1));
      bus.start  = 1'($urandom_range(0, 1));
      bus.k_len  = KW'($urandom_range(0, 20));
      settle();
      chk("out_valid_hold", bus.out_valid, 1);
      chk("ld_a_en_in_done", bus.ld_a_en, 0);
      chk("ld_b_en_in_done", bus.ld_b_en, 0);
      chk("err_klen_in_done", bus.err_klen, 0);
      chk("busy_in_done", bus.busy, 0);
    end
  endtask

  task automatic handshake_done(input int klen);
    next_cycle();
    idle_inputs();
    bus.out_ready = 1'b1;
    settle();
    chk("out_valid_handshake", bus.out_valid, 1);
    next_cycle();
    idle_inputs();
    settle();
    chk("out_valid_dropped", bus.out_valid, 0);
    chk("busy_after_handshake", bus.busy, 0);
    chk("k_index_kept_idle", bus.k_index, klen - 1);
  endtask

  initial begin
    bit fin;
    int klen, ab_at;
    bit acc;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    idle_inputs();

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_k_index", bus.k_index, 0);
    chk("rst_compute", bus.compute_en, 0);
    chk("rst_clear", bus.clear_acc, 0);
    next_cycle();
    reset_n = 1'b1;

    // load_A for three cycles, then released
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle_inputs();
      bus.load_A = (i < 3);
      settle();
      chk("ld_a_en_seq", bus.ld_a_en, (i < 3));
      chk("ld_b_en_quiet", bus.ld_b_en, 0);
      chk("busy_in_load", bus.busy, 0);
    end

    // load takes priority over a simultaneous start
    next_cycle();
    idle_inputs();
    bus.load_B = 1'b1; bus.start = 1'b1; bus.k_len = KW'(4);
    settle();
    chk("ld_b_en_prio", bus.ld_b_en, 1);
    chk("err_klen_prio", bus.err_klen, 0);
    next_cycle();
    idle_inputs();
    settle();
    chk("busy_not_launched", bus.busy, 0);
    chk("clear_not_launched", bus.clear_acc, 0);

    // k_len=4 clear mode, result held 5 cycles
    run_op(4, 1'b0, 1'b0, -1, fin);
    chk("t2_finished", fin, 1);
    hold_done(5);
    handshake_done(4);

    // accumulate mode, k_len = K_MAX
    run_op(K_MAX, 1'b1, 1'b0, -1, fin);
    chk("t3_finished", fin, 1);
    handshake_done(K_MAX);

    // illegal lengths
    run_op(0, 1'b0, 1'b0, -1, fin);
    run_op(17, 1'b0, 1'b0, -1, fin);

    // abort at k_index 2 of k_len 8 (compute starts in cycle 3)
    run_op(8, 1'b0, 1'b0, 5, fin);
    chk("t5_not_finished", fin, 0);

    // back-to-back relaunch on handshake, then an illegal start on handshake
    run_op(5, 1'b0, 1'b0, -1, fin);
    hold_done(2);
    run_op(3, 1'b0, 1'b1, -1, fin);
    chk("t6_finished", fin, 1);
    run_op(17, 1'b1, 1'b1, -1, fin);

    // reset pulse in the middle of COMPUTE
    next_cycle();
    idle_inputs();
    bus.start = 1'b1; bus.k_len = KW'(6);
    repeat (4) begin
      next_cycle();
      idle_inputs();
    end
    settle();
    chk("pre_reset_compute", bus.compute_en, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_compute", bus.compute_en, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_k_index", bus.k_index, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    next_cycle();
    reset_n = 1'b1;

    // randomized tiles
    for (int n = 0; n < 30; n++) begin
      klen  = $urandom_range(0, 20);
      acc   = 1'($urandom_range(0, 1));
      ab_at = -1;
      if (klen >= 1 && klen <= K_MAX && $urandom_range(0, 3) == 0)
        ab_at = $urandom_range(1, (acc ? 2 : 3) + klen + D - 1);
      run_op(klen, acc, 1'b0, ab_at, fin);
      if (fin) begin
        hold_done($urandom_range(0, 3));
        handshake_done(klen);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
